// File: rtl/fpu_ext_pkg.sv
// Shared definitions for the external FPU arbiter and the FPU it fronts:
// arbiter state encoding and funct3 opcode constants.
package fpu_ext_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] FUNCT3_FADD  = 3'd0;
    localparam logic [2:0] FUNCT3_FSUB  = 3'd1;
    localparam logic [2:0] FUNCT3_FMUL  = 3'd2;
    localparam logic [2:0] FUNCT3_FDIV  = 3'd3;
    localparam logic [2:0] FUNCT3_FSQRT = 3'd4;
    localparam logic [2:0] FUNCT3_FMIN  = 3'd5;
    localparam logic [2:0] FUNCT3_FMAX  = 3'd6;
    localparam logic [2:0] FUNCT3_FCMP  = 3'd7;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_ext_arb.sv
// Arbitrates two requesters onto one external FPU: latches the winner's operands,
// issues a start pulse, waits (with timeout) for the result and returns it as a ready pulse.
module fpu_ext_arb
    import fpu_ext_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_rs1,
    input  logic [31:0] i_req0_rs2,
    input  logic [2:0]  i_req0_funct3,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_rs1,
    input  logic [31:0] i_req1_rs2,
    input  logic [2:0]  i_req1_funct3,
    output logic        o_req0_ready,
    output logic [31:0] o_req0_rd,
    output logic        o_req1_ready,
    output logic [31:0] o_req1_rd,
    output logic        o_fpu_valid,
    output logic [31:0] o_fpu_a,
    output logic [31:0] o_fpu_b,
    output logic [2:0]  o_fpu_op,
    input  logic        i_fpu_ready,
    input  logic [31:0] i_fpu_o,
    output logic        o_busy,
    output logic        o_grant,
    output logic        o_timeout_err,
    input  logic        i_clr_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_inc;
    logic [1:0]    armed;
    logic [1:0]    eligible;
    logic          last_grant;
    logic          grant;
    logic          pick;
    logic          accept;
    logic          fpu_done;
    logic          timeout_hit;
    logic          fpu_valid;
    logic          ready0;
    logic          ready1;
    logic          timeout_err;
    logic [31:0]   fpu_a;
    logic [31:0]   fpu_b;
    logic [2:0]    fpu_op;
    logic [31:0]   result;

    assign eligible    = {i_req1_valid, i_req0_valid} & armed;
    assign cnt_inc     = cnt + TW'(1);
    assign accept      = (state == IDLE) && (|eligible);
    assign fpu_done    = (state == WAIT) && i_fpu_ready;
    // A done pulse in the final WAIT cycle beats the timeout.
    assign timeout_hit = (state == WAIT) && !i_fpu_ready && (cnt_inc == TW'(TIMEOUT));

    rr_arb2 u_rr_arb2 (
        .req   (eligible),
        .last  (last_grant),
        .grant (pick)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= IDLE;
            fpu_valid   <= 1'b0;
            ready0      <= 1'b0;
            ready1      <= 1'b0;
            timeout_err <= 1'b0;
            last_grant  <= 1'b1;
            grant       <= 1'b1;
            armed       <= 2'b11;
            cnt         <= '0;
        end else begin
            fpu_valid <= 1'b0;
            ready0    <= 1'b0;
            ready1    <= 1'b0;
            if (i_clr_err) begin
                timeout_err <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        grant     <= pick;
                        fpu_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fpu_done || timeout_hit) begin
                        ready0 <= ~grant;
                        ready1 <= grant;
                        state  <= RESP;
                    end
                    if (!fpu_done) begin
                        cnt <= cnt_inc;
                    end
                    if (timeout_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                RESP: begin
                    armed[grant] <= 1'b0;
                    last_grant   <= grant;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A low valid re-arms its requester even in RESP, so a request withdrawn
            // during its own response is not mistaken for one still being held.
            if (!i_req0_valid) begin
                armed[0] <= 1'b1;
            end
            if (!i_req1_valid) begin
                armed[1] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            if (accept) begin
                fpu_a  <= pick ? i_req1_rs1    : i_req0_rs1;
                fpu_b  <= pick ? i_req1_rs2    : i_req0_rs2;
                fpu_op <= pick ? i_req1_funct3 : i_req0_funct3;
            end
            if (fpu_done) begin
                result <= i_fpu_o;
            end else if (timeout_hit) begin
                result <= '0;
            end
        end
    end

    assign o_fpu_valid   = fpu_valid;
    assign o_fpu_a       = fpu_a;
    assign o_fpu_b       = fpu_b;
    assign o_fpu_op      = fpu_op;
    assign o_req0_ready  = ready0;
    assign o_req1_ready  = ready1;
    assign o_req0_rd     = result;
    assign o_req1_rd     = result;
    assign o_busy        = (state != IDLE);
    assign o_grant       = grant;
    assign o_timeout_err = timeout_err;

endmodule

// File: doc/fpu_ext_arb.md
FPU_EXT_ARB -- requirements
Module: fpu_ext_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before an FPU operation is abandoned (range 1..65535).
REQ-002 SHALL have localparam TW = $clog2(TIMEOUT+1), meaning the timeout counter width.
REQ-003 SHALL have ports, with clock and reset first:
- clk  in  1  — single clock for all logic.
- i_rst  in  1  — synchronous, active-high reset.
- i_req0_valid / i_req1_valid  in  1  — requester N operation pending, held level until its ready.
- i_req0_rs1 / i_req1_rs1  in  32  — operand A.
- i_req0_rs2 / i_req1_rs2  in  32  — operand B.
- i_req0_funct3 / i_req1_funct3  in  3  — FPU opcode.
- o_req0_ready / o_req1_ready  out  1  — one-cycle completion pulse.
- o_req0_rd / o_req1_rd  out  32  — result, valid while ready is high.
- o_fpu_valid  out  1  — one-cycle start pulse to the FPU.
- o_fpu_a / o_fpu_b  out  32  — latched operands.
- o_fpu_op  out  3  — latched opcode.
- i_fpu_ready  in  1  — FPU done pulse.
- i_fpu_o  in  32  — FPU result.
- o_busy  out  1  — high in any state other than IDLE.
- o_grant  out  1  — index of the requester currently or last served.
- o_timeout_err  out  1  — sticky flag: an operation timed out.
- i_clr_err  in  1  — clears o_timeout_err.

Function
REQ-004 SHALL implement a four-state FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-005 In IDLE, a requester SHALL be eligible when its valid is high and its armed flag is set.
REQ-006 IDLE: if any requester is eligible, the block SHALL grant it, latch its rs1, rs2 and funct3 into o_fpu_a, o_fpu_b and o_fpu_op, and go to ISSUE.
REQ-007 Arbitration SHALL be round-robin: when both requesters are eligible, the one not equal to last_grant wins; when only one is eligible, it wins.
REQ-008 ISSUE SHALL assert o_fpu_valid for exactly one cycle, clear the timeout counter and go to WAIT.
REQ-009 WAIT: on i_fpu_ready the block SHALL latch i_fpu_o into the result register and go to RESP.
REQ-010 WAIT without i_fpu_ready: the counter SHALL increment; when it equals TIMEOUT, the result register SHALL be loaded with 0, o_timeout_err SHALL be set, and the FSM SHALL go to RESP.
REQ-011 If i_fpu_ready arrives in the same cycle the counter reaches TIMEOUT, i_fpu_ready SHALL win: the result is latched and no error is flagged.
REQ-012 RESP SHALL pulse o_reqG_ready for one cycle (G = granted requester), clear armed[G], set last_grant = G and return to IDLE.
REQ-013 o_reqN_rd SHALL be driven with the result register; it is only meaningful while o_reqN_ready is high.
REQ-014 armed[N] SHALL be set in any cycle in which i_reqN_valid is low; this prevents re-accepting a request that is still held high after its ready pulse.
REQ-015 i_fpu_ready SHALL be ignored outside WAIT.
REQ-016 A requester's valid dropping while it is granted SHALL NOT abort the operation, and its ready SHALL still pulse.
REQ-017 o_fpu_a, o_fpu_b and o_fpu_op SHALL remain stable from ISSUE through RESP.
REQ-018 Latency: eligible valid in IDLE at cycle 0 -> o_fpu_valid at cycle 1 -> WAIT from cycle 2 -> i_fpu_ready at cycle k -> o_reqG_ready at cycle k+1.
REQ-019 Minimum request-to-ready latency SHALL be 3 cycles, which occurs when i_fpu_ready arrives at cycle 2.
REQ-020 Back-to-back throughput: after RESP, the other requester SHALL be grantable in the very next IDLE cycle.
REQ-021 i_clr_err SHALL clear o_timeout_err; if a timeout occurs in the same cycle, the set SHALL win.
REQ-022 o_busy SHALL be combinational: (state != IDLE).

Reset
REQ-023 On i_rst, sampled at the clk edge, the FSM SHALL go to IDLE.
REQ-024 On i_rst the following SHALL be cleared: o_fpu_valid = 0, both o_reqN_ready = 0, o_timeout_err = 0, last_grant = 1 (so requester 0 wins the first tie), armed = 2'b11, and counter = 0.
REQ-025 On i_rst, the operand, opcode and result registers SHALL NOT be reset, and their outputs are undefined until the first grant.
REQ-026 A reset during ISSUE, WAIT or RESP SHALL abandon the operation without any ready pulse; a late i_fpu_ready arriving afterwards is ignored per REQ-015.

Structure
REQ-027 A shared package fpu_ext_pkg SHALL hold the state encoding (IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3) and the funct3 opcode constants shared with the fpu.
REQ-028 The round-robin pick SHALL be a sub-module rr_arb2, with inputs req[1:0] and last and output grant, purely combinational.
REQ-029 All other logic SHALL reside in fpu_ext_arb.

Verification
REQ-030 Single request: req0 with rs1 = 0x3F800000, rs2 = 0x40000000, funct3 = 0; FPU returns 0x40400000 at cycle 4 -> o_req0_ready pulses at cycle 5 with o_req0_rd = 0x40400000, and o_fpu_valid is high only at cycle 1.
REQ-031 Simultaneous requests from reset: both valid at cycle 0 -> req0 is served first, then req1; grant order is 0, 1, 0, 1 over four repeated pairs.
REQ-032 Held valid: req0 valid stays high 3 cycles after its ready -> no second FPU issue until req0 valid has been low for 1 cycle.
REQ-033 Timeout: TIMEOUT = 4, FPU never responds -> ready pulses with rd = 0 and o_timeout_err = 1; after i_clr_err, o_timeout_err = 0.
REQ-034 Race: i_fpu_ready with 0x12345678 arrives in the same cycle the counter reaches TIMEOUT -> rd = 0x12345678 and o_timeout_err stays 0.
REQ-035 Reset mid-WAIT: i_rst asserted during WAIT, then i_fpu_ready pulsed -> no ready pulse, o_busy = 0, and the next request is served normally.
